// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter family.
package piso_pkg;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    localparam int PISO_WIDTH_DEF = 4;

endpackage

// File: rtl/piso_shift_tx_bit_counter.sv
// Synchronous up-counter with clear, enable and terminal-count flag.
// Saturates at WIDTH-1; clear takes priority over enable.
module bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    assign terminal = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rest) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: valid/ready word load, valid/ready bit stream
// with a last-bit flag. All outputs decode from registered state only.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rest,
    input  logic [WIDTH-1:0] D,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    piso_state_t      state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CNT_W-1:0] count;
    logic             terminal;
    logic             out_bit;
    logic             load_fire;
    logic             accept;
    logic             cnt_clear;

    assign out_bit       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};

    bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .rest     (rest),
        .clear    (cnt_clear),
        .en       (accept),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clk) begin
        if (rest) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            shreg <= '0;
        end else if (load_fire) begin
            shreg <= D;
        end else if (accept) begin
            shreg <= shreg_shifted;
        end
    end

    always_comb begin
        state_next = state;
        load_fire  = 1'b0;
        accept     = 1'b0;
        cnt_clear  = 1'b0;
        load_ready = 1'b0;
        busy       = 1'b0;
        sout_valid = 1'b0;
        sout       = 1'b0;
        sout_last  = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    load_fire  = 1'b1;
                    cnt_clear  = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = out_bit;
                sout_last  = terminal;
                accept     = sout_ready;
                // Final beat returns to IDLE, forcing at least one idle cycle between words.
                if (sout_ready && terminal) begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Randomized and directed bench for piso_shift_tx, MSB-first and LSB-first instances side by side.
module tb_piso_shift_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rest;
    logic [W-1:0] D;
    logic         load_valid;
    logic         sout_ready;

    logic lr_m, so_m, sv_m, sl_m, bz_m;
    logic lr_l, so_l, sv_l, sl_l, bz_l;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: the word in flight and how many bits have been accepted.
    bit           m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_idx  = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk        (clk),
        .rest       (rest),
        .D          (D),
        .load_valid (load_valid),
        .load_ready (lr_m),
        .sout       (so_m),
        .sout_valid (sv_m),
        .sout_ready (sout_ready),
        .sout_last  (sl_m),
        .busy       (bz_m)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk        (clk),
        .rest       (rest),
        .D          (D),
        .load_valid (load_valid),
        .load_ready (lr_l),
        .sout       (so_l),
        .sout_valid (sv_l),
        .sout_ready (sout_ready),
        .sout_last  (sl_l),
        .busy       (bz_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic lv, input logic [W-1:0] d, input logic sr, input logic rs);
        if (rs) begin
            m_busy = 1'b0;
            m_idx  = 0;
        end else if (!m_busy) begin
            if (lv) begin
                m_busy = 1'b1;
                m_word = d;
                m_idx  = 0;
            end
        end else if (sr) begin
            if (m_idx == W - 1) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic check_outputs();
        logic e_m, e_l, e_last;
        e_m    = m_busy ? m_word[W-1-m_idx] : 1'b0;
        e_l    = m_busy ? m_word[m_idx]     : 1'b0;
        e_last = m_busy && (m_idx == W - 1);
        chk("m_load_ready", lr_m, !m_busy);
        chk("m_busy",       bz_m, m_busy);
        chk("m_sout_valid", sv_m, m_busy);
        chk("m_sout",       so_m, e_m);
        chk("m_sout_last",  sl_m, e_last);
        chk("l_load_ready", lr_l, !m_busy);
        chk("l_busy",       bz_l, m_busy);
        chk("l_sout_valid", sv_l, m_busy);
        chk("l_sout",       so_l, e_l);
        chk("l_sout_last",  sl_l, e_last);
    endtask

    // Apply inputs for one clock, advance the model at the edge, check at the falling edge.
    task automatic tick(input logic lv, input logic [W-1:0] d, input logic sr, input logic rs);
        load_valid = lv;
        D          = d;
        sout_ready = sr;
        rest       = rs;
        @(posedge clk);
        model_update(lv, d, sr, rs);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [W-1:0] seq_m;
        logic [W-1:0] seq_l;

        rest = 1'b1; load_valid = 1'b0; D = '0; sout_ready = 1'b0;
        @(negedge clk);

        // Reset held for two cycles while load_valid toggles.
        for (int i = 0; i < 2; i++) begin
            tick(1'($urandom_range(0, 1)), W'($urandom), 1'b1, 1'b1);
            chk("rst_load_ready", lr_m, 1'b1);
            chk("rst_sout_valid", sv_m, 1'b0);
            chk("rst_sout",       so_m, 1'b0);
            chk("rst_busy",       bz_m, 1'b0);
        end
        tick(1'b0, '0, 1'b1, 1'b0);

        // Basic word 1011: MSB-first 1,0,1,1 and LSB-first 1,1,0,1.
        seq_m = 4'b1011;
        seq_l = 4'b1101;
        tick(1'b1, 4'b1011, 1'b1, 1'b0);
        chk("basic_m_b0", so_m, seq_m[3]);
        chk("basic_l_b0", so_l, seq_l[3]);
        for (int i = 1; i < W; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            chk("basic_m_bit",  so_m, seq_m[3-i]);
            chk("basic_l_bit",  so_l, seq_l[3-i]);
            chk("basic_last",   sl_m, (i == W - 1));
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        chk("basic_ready_back", lr_m, 1'b1);

        // Backpressure on 0110: third bit held for three stalled cycles.
        tick(1'b1, 4'b0110, 1'b1, 1'b0);
        chk("bp_b0", so_m, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        chk("bp_b1", so_m, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b0);
        chk("bp_b2", so_m, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b0, 1'b0);
            chk("bp_hold",      so_m, 1'b1);
            chk("bp_hold_last", sl_m, 1'b0);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        chk("bp_b3",      so_m, 1'b0);
        chk("bp_b3_last", sl_m, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b0);

        // Loads offered during SHIFT are ignored until load_ready returns.
        tick(1'b1, 4'b1111, 1'b1, 1'b0);
        for (int i = 1; i < W; i++) begin
            tick(1'b1, 4'b0000, 1'b1, 1'b0);
            chk("ld_shift_bit", so_m, 1'b1);
        end
        tick(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("ld_shift_ready", lr_m, 1'b1);
        tick(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("ld_shift_taken", bz_m, 1'b1);
        chk("ld_shift_zero",  so_m, 1'b0);
        for (int i = 0; i < W; i++) tick(1'b0, '0, 1'b1, 1'b0);

        // Reset after two accepted bits of 1001 aborts the word.
        tick(1'b1, 4'b1001, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b1);
        chk("abort_valid", sv_m, 1'b0);
        chk("abort_last",  sl_m, 1'b0);
        chk("abort_ready", lr_m, 1'b1);
        seq_m = 4'b0101;
        tick(1'b1, 4'b0101, 1'b1, 1'b0);
        chk("after_abort_b0", so_m, seq_m[3]);
        for (int i = 1; i < W; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            chk("after_abort_bit", so_m, seq_m[3-i]);
        end
        tick(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic with backpressure and occasional reset.
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 1)), W'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
